// File: rtl/fsm_menu_multi.sv
// fsm_menu_multi: keypad-driven room/sensor menu that builds a 2-byte request frame and
// handshakes it with a local UART and an external TX engine, with timeout/retry, a back
// key and periodic auto-refresh of the selected sensor.
// Ports: clk/rst (sync, active-high); key_valid/key_col/key_back keypad events;
//   tx_done_pulse/ext_tx_done_pulse engine completions; tx_start/tx_byte1/tx_byte2 frame out;
//   sel_sala/sel_sensor current selection; menu_state FSM code; err_timeout abort pulse.
module fsm_menu_multi #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int N_SALAS     = 4,
  parameter int N_SENSORES  = 4,
  parameter int HOLDOFF_CYC = CLK_FREQ / 2,
  parameter int TIMEOUT_CYC = CLK_FREQ / 10,
  parameter int MAX_RETRY   = 3,
  parameter int AUTO_CYC    = CLK_FREQ / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_col,
  input  logic       key_back,
  input  logic       tx_done_pulse,
  input  logic       ext_tx_done_pulse,
  output logic       tx_start,
  output logic [7:0] tx_byte1,
  output logic [7:0] tx_byte2,
  output logic [3:0] sel_sala,
  output logic [3:0] sel_sensor,
  output logic [2:0] menu_state,
  output logic       err_timeout
);

  localparam logic [2:0] S_SALA    = 3'd0;
  localparam logic [2:0] S_SENSOR  = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_MONITOR = 3'd4;

  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(AUTO_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [4:0] N_SALA5 = 5'(N_SALAS);
  localparam logic [4:0] N_SENS5 = 5'(N_SENSORES);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [HW-1:0] holdoff_cnt;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] auto_cnt;
  logic [RW-1:0] retry_cnt;
  logic          done_flag;
  logic          ext_done_flag;
  logic          origin_sensor;
  logic [7:0]    seq;
  logic [7:0]    byte1_q;
  logic [7:0]    byte2_q;

  logic in_range;
  logic key_acc;
  logic both_done;
  logic to_hit;
  logic auto_hit;
  logic retry_ok;
  logic abort;

  // Key decode. A simultaneous back press always discards the key, and only
  // the three menu states take keys at all.
  always_comb begin
    in_range  = (state == S_SALA) ? ({1'b0, key_col} < N_SALA5)
                                  : ({1'b0, key_col} < N_SENS5);
    key_acc   = key_valid && !key_back && (holdoff_cnt == '0) && in_range &&
                ((state == S_SALA) || (state == S_SENSOR) || (state == S_MONITOR));
    // A pulse arriving this cycle counts immediately, not only once it is sticky.
    both_done = (done_flag | tx_done_pulse) & (ext_done_flag | ext_tx_done_pulse);
    to_hit    = (to_cnt == TW'(TIMEOUT_CYC - 1));
    auto_hit  = (auto_cnt == AW'(AUTO_CYC - 1));
    retry_ok  = (retry_cnt < RW'(MAX_RETRY));
    abort     = (state == S_WAIT) && !both_done && to_hit && !retry_ok;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_SALA;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_SALA:    if (key_acc) state_nxt = S_SEND;
      S_SENSOR: begin
        if (key_back)     state_nxt = S_SALA;
        else if (key_acc) state_nxt = S_SEND;
      end
      S_SEND:    state_nxt = S_WAIT;
      S_WAIT: begin
        if (both_done)   state_nxt = origin_sensor ? S_MONITOR : S_SENSOR;
        else if (to_hit) state_nxt = retry_ok ? S_SEND : S_SALA;
      end
      S_MONITOR: begin
        if (key_back)               state_nxt = S_SENSOR;
        else if (key_acc || auto_hit) state_nxt = S_SEND;
      end
      default:   state_nxt = S_SALA;
    endcase
  end

  // Outputs. The frame is driven live from the selection during SEND and
  // held from the captured copy afterwards.
  always_comb begin
    tx_start   = (state == S_SEND);
    tx_byte1   = (state == S_SEND) ? {sel_sensor, sel_sala} : byte1_q;
    tx_byte2   = (state == S_SEND) ? seq : byte2_q;
    menu_state = state;
  end

  // Datapath: selection, counters, handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      holdoff_cnt   <= '0;
      to_cnt        <= '0;
      auto_cnt      <= '0;
      retry_cnt     <= '0;
      done_flag     <= 1'b0;
      ext_done_flag <= 1'b0;
      origin_sensor <= 1'b0;
      seq           <= 8'd0;
      byte1_q       <= 8'd0;
      byte2_q       <= 8'd0;
      sel_sala      <= 4'd0;
      sel_sensor    <= 4'd0;
      err_timeout   <= 1'b0;
    end else begin
      err_timeout <= abort;

      if (key_acc)                  holdoff_cnt <= HW'(HOLDOFF_CYC);
      else if (holdoff_cnt != '0)   holdoff_cnt <= holdoff_cnt - 1'b1;

      case (state)
        S_SALA: if (key_acc) begin
          sel_sala      <= key_col + 4'd1;
          sel_sensor    <= 4'd0;
          origin_sensor <= 1'b0;
        end
        S_SENSOR: begin
          if (key_back) sel_sala <= 4'd0;
          else if (key_acc) begin
            sel_sensor    <= key_col + 4'd1;
            origin_sensor <= 1'b1;
          end
        end
        S_SEND: begin
          seq           <= seq + 8'd1;
          byte1_q       <= {sel_sensor, sel_sala};
          byte2_q       <= seq;
          done_flag     <= 1'b0;
          ext_done_flag <= 1'b0;
          to_cnt        <= '0;
        end
        S_WAIT: begin
          done_flag     <= done_flag | tx_done_pulse;
          ext_done_flag <= ext_done_flag | ext_tx_done_pulse;
          to_cnt        <= to_cnt + 1'b1;
          if (both_done) retry_cnt <= '0;
          else if (to_hit) begin
            if (retry_ok) retry_cnt <= retry_cnt + 1'b1;
            else begin
              retry_cnt  <= '0;
              sel_sala   <= 4'd0;
              sel_sensor <= 4'd0;
            end
          end
        end
        S_MONITOR: begin
          if (key_back) sel_sensor <= 4'd0;
          else if (key_acc) begin
            sel_sensor    <= key_col + 4'd1;
            origin_sensor <= 1'b1;
          end
        end
        default: ;
      endcase

      // Refresh timer runs only while the FSM stays in MONITOR.
      if ((state == S_MONITOR) && (state_nxt == S_MONITOR)) auto_cnt <= auto_cnt + 1'b1;
      else                                                   auto_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fsm_menu_multi.sv
module tb_fsm_menu_multi;

  localparam int HOLD = 12;
  localparam int TOUT = 8;
  localparam int AUTO = 16;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_col = 4'd0;
  logic       key_back = 1'b0;
  logic       tx_done_pulse = 1'b0;
  logic       ext_tx_done_pulse = 1'b0;
  logic       tx_start;
  logic [7:0] tx_byte1;
  logic [7:0] tx_byte2;
  logic [3:0] sel_sala;
  logic [3:0] sel_sensor;
  logic [2:0] menu_state;
  logic       err_timeout;

  fsm_menu_multi #(
    .CLK_FREQ(100), .N_SALAS(4), .N_SENSORES(4), .HOLDOFF_CYC(HOLD),
    .TIMEOUT_CYC(TOUT), .MAX_RETRY(MAXR), .AUTO_CYC(AUTO)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_col(key_col), .key_back(key_back),
    .tx_done_pulse(tx_done_pulse), .ext_tx_done_pulse(ext_tx_done_pulse),
    .tx_start(tx_start), .tx_byte1(tx_byte1), .tx_byte2(tx_byte2),
    .sel_sala(sel_sala), .sel_sensor(sel_sensor), .menu_state(menu_state),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every tx_start must match the oldest expected frame.
  always @(negedge clk) begin
    if (tx_start) begin
      if (sb.size() == 0) begin
        chk("unexpected_tx_start", {tx_byte1, tx_byte2}, 0);
        if ({tx_byte1, tx_byte2} == 16'd0) begin
          n_err++;
          $display("FAIL unexpected_tx_start: got frame 0x0000 expected none at %0t", $time);
        end
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("frame", {tx_byte1, tx_byte2}, e);
      end
    end
  end

  typedef struct {
    logic       kv;
    logic [3:0] col;
    logic       back;
    logic       done;
    logic       ext;
    logic [2:0] st;
    logic [3:0] sala;
    logic [3:0] sen;
    logic       start;
    logic       push;
    logic [15:0] frame;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic kv, input logic [3:0] col, input logic back, input logic done,
                     input logic ext, input logic [2:0] st, input logic [3:0] sala,
                     input logic [3:0] sen, input logic start, input logic push,
                     input logic [15:0] frame);
    vec_t v;
    v.kv = kv; v.col = col; v.back = back; v.done = done; v.ext = ext;
    v.st = st; v.sala = sala; v.sen = sen; v.start = start; v.push = push; v.frame = frame;
    tbl.push_back(v);
  endtask

  // One clock: drive at negedge, sample at the following negedge.
  task automatic cyc(input logic kv, input logic [3:0] col, input logic back,
                     input logic done, input logic ext);
    key_valid = kv; key_col = col; key_back = back;
    tx_done_pulse = done; ext_tx_done_pulse = ext;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0; key_back = 1'b0; tx_done_pulse = 1'b0; ext_tx_done_pulse = 1'b0;
  endtask

  task automatic expect_st(input string tag, input logic [2:0] st, input logic [3:0] sala,
                           input logic [3:0] sen, input logic start);
    chk({tag, "_state"}, menu_state, st);
    chk({tag, "_sala"}, sel_sala, sala);
    chk({tag, "_sensor"}, sel_sensor, sen);
    chk({tag, "_start"}, tx_start, start);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    // Main walk: room 2, split done pulses, holdoff, out-of-range, sensor 3, MONITOR.
    add(1, 4'd1, 0, 0, 0, 3'd2, 4'd2, 4'd0, 1, 1, 16'h0200);
    add(0, 4'd0, 0, 0, 0, 3'd3, 4'd2, 4'd0, 0, 0, 16'h0);
    add(0, 4'd0, 0, 1, 0, 3'd3, 4'd2, 4'd0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) add(0, 4'd0, 0, 0, 0, 3'd3, 4'd2, 4'd0, 0, 0, 16'h0);
    add(0, 4'd0, 0, 0, 1, 3'd1, 4'd2, 4'd0, 0, 0, 16'h0);
    add(1, 4'd2, 0, 0, 0, 3'd1, 4'd2, 4'd0, 0, 0, 16'h0);
    add(1, 4'd4, 0, 0, 0, 3'd1, 4'd2, 4'd0, 0, 0, 16'h0);
    add(0, 4'd0, 0, 0, 0, 3'd1, 4'd2, 4'd0, 0, 0, 16'h0);
    add(0, 4'd0, 0, 0, 0, 3'd1, 4'd2, 4'd0, 0, 0, 16'h0);
    add(1, 4'd1, 0, 0, 0, 3'd1, 4'd2, 4'd0, 0, 0, 16'h0);
    add(1, 4'd4, 0, 0, 0, 3'd1, 4'd2, 4'd0, 0, 0, 16'h0);
    add(1, 4'd2, 0, 0, 0, 3'd2, 4'd2, 4'd3, 1, 1, 16'h3201);
    add(0, 4'd0, 0, 0, 0, 3'd3, 4'd2, 4'd3, 0, 0, 16'h0);
    add(0, 4'd0, 0, 1, 1, 3'd4, 4'd2, 4'd3, 0, 0, 16'h0);

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_st("reset", 3'd0, 4'd0, 4'd0, 0);
    chk("reset_byte1", tx_byte1, 8'h00);
    chk("reset_byte2", tx_byte2, 8'h00);
    chk("reset_err", err_timeout, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].push) sb.push_back(tbl[i].frame);
      cyc(tbl[i].kv, tbl[i].col, tbl[i].back, tbl[i].done, tbl[i].ext);
      expect_st($sformatf("vec%0d", i), tbl[i].st, tbl[i].sala, tbl[i].sen, tbl[i].start);
    end

    // Auto refresh after AUTO cycles in MONITOR
    for (int i = 0; i < AUTO - 1; i++) begin
      cyc(0, 4'd0, 0, 0, 0);
      chk("auto_hold_state", menu_state, 3'd4);
      chk("auto_hold_start", tx_start, 0);
    end
    sb.push_back(16'h3202);
    cyc(0, 4'd0, 0, 0, 0);
    expect_st("auto_send", 3'd2, 4'd2, 4'd3, 1);
    cyc(0, 4'd0, 0, 0, 0);
    cyc(0, 4'd0, 0, 1, 1);
    expect_st("auto_back_mon", 3'd4, 4'd2, 4'd3, 0);
    chk("held_byte2", tx_byte2, 8'h02);

    // back + key same cycle in MONITOR: back wins
    cyc(1, 4'd0, 1, 0, 0);
    expect_st("mon_back", 3'd1, 4'd2, 4'd0, 0);

    // Timeout: only local done each round, 3 resends then abort
    sb.push_back(16'h1203);
    cyc(1, 4'd0, 0, 0, 0);
    expect_st("to_send", 3'd2, 4'd2, 4'd1, 1);
    cyc(0, 4'd0, 0, 0, 0);
    chk("to_wait", menu_state, 3'd3);
    for (int r = 0; r <= MAXR; r++) begin
      for (int c = 0; c < TOUT - 1; c++) begin
        cyc(0, 4'd0, 0, (c == 0), 0);
        chk("to_waiting", menu_state, 3'd3);
      end
      if (r < MAXR) begin
        sb.push_back({8'h12, 8'(4 + r)});
        cyc(0, 4'd0, 0, 0, 0);
        expect_st("to_resend", 3'd2, 4'd2, 4'd1, 1);
        chk("to_resend_err", err_timeout, 0);
        cyc(0, 4'd0, 0, 0, 0);
        chk("to_rewait", menu_state, 3'd3);
      end else begin
        cyc(0, 4'd0, 0, 0, 0);
        expect_st("to_abort", 3'd0, 4'd0, 4'd0, 0);
        chk("to_abort_err", err_timeout, 1);
        cyc(0, 4'd0, 0, 0, 0);
        chk("to_err_pulse", err_timeout, 0);
      end
    end

    // Reset in the middle of WAIT
    sb.push_back(16'h0407);
    cyc(1, 4'd3, 0, 0, 0);
    expect_st("rw_send", 3'd2, 4'd4, 4'd0, 1);
    cyc(0, 4'd0, 0, 0, 0);
    chk("rw_wait", menu_state, 3'd3);
    rst = 1'b1;
    cyc(0, 4'd0, 0, 0, 0);
    rst = 1'b0;
    expect_st("rw_reset", 3'd0, 4'd0, 4'd0, 0);
    chk("rw_byte1", tx_byte1, 8'h00);
    chk("rw_byte2", tx_byte2, 8'h00);
    cyc(0, 4'd0, 0, 1, 0);
    cyc(0, 4'd0, 0, 0, 1);
    cyc(0, 4'd0, 0, 1, 1);
    expect_st("rw_late_done", 3'd0, 4'd0, 4'd0, 0);

    // Out-of-range room key starts no holdoff; next valid key is taken at once
    cyc(1, 4'd4, 0, 0, 0);
    expect_st("oor_sala", 3'd0, 4'd0, 4'd0, 0);
    sb.push_back(16'h0100);
    cyc(1, 4'd0, 0, 0, 0);
    expect_st("post_oor", 3'd2, 4'd1, 4'd0, 1);
    cyc(0, 4'd0, 0, 0, 0);
    cyc(0, 4'd0, 0, 1, 1);
    expect_st("post_oor_done", 3'd1, 4'd1, 4'd0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
